// File: rtl/x7seg_pkg.sv
// Shared definitions for the four-digit multiplexed hex display scanner.
package x7seg_pkg;

  localparam int unsigned NUM_DIGITS          = 4;
  localparam int unsigned REFRESH_DIV_DEFAULT = 100000;

  typedef logic [1:0] digit_idx_t;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // One complete display image: four nibbles plus per-digit blank and dp.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } disp_t;

  // Extract digit idx (digit 0 = rightmost nibble).
  function automatic logic [3:0] digit_nibble(input logic [15:0] data, input digit_idx_t idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/x7seg_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and raises tick on the last count.
module x7seg_tick
  import x7seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned      CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]    LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running slot counter, wraps after the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/x7seg_scan.sv
// Four-digit multiplexed hex display scanner.
// New values are double-buffered and only committed at a frame boundary,
// so a frame never shows a mix of old and new digits.
// Optional leading-zero suppression is enabled by defining X7SEG_LZB_EN.
module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [3:0]  nibble,
  output logic        dp_n,
  output logic        busy
);

  logic       tick;
  logic       boundary;
  digit_idx_t idx;
  digit_idx_t idx_next;
  disp_t      disp;
  disp_t      disp_next;
  disp_t      pend;
  disp_t      load_val;
  logic [3:0] sup;
  logic [3:0] eff_blank;

  x7seg_tick #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign boundary = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
  assign idx_next = idx + 1'b1;
  assign load_val = {data, blank, dp};

  // Display image seen by the next frame; a load on the boundary bypasses pending.
  always_comb begin
    disp_next = disp;
    if (boundary) begin
      if (load)      disp_next = load_val;
      else if (busy) disp_next = pend;
    end
  end

  // Scan index, display/pending buffers and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      disp <= '0;
      pend <= '0;
      busy <= 1'b0;
    end else begin
      if (tick) idx <= idx_next;
      disp <= disp_next;
      if (boundary) begin
        busy <= 1'b0;
      end else if (load) begin
        pend <= load_val;
        busy <= 1'b1;
      end
    end
  end

`ifdef X7SEG_LZB_EN
  // Leading-zero suppression from digit 3 down; digit 0 always shown.
  always_comb begin
    logic       lead;
    digit_idx_t d;
    sup  = '0;
    lead = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
      d = digit_idx_t'(NUM_DIGITS - 1 - i);
      if (lead && (digit_nibble(disp_next.data, d) == 4'h0) && !disp_next.dp[d])
        sup[d] = 1'b1;
      else
        lead = 1'b0;
    end
  end
`else
  // No suppression in this build.
  always_comb begin
    sup = '0;
  end
`endif

  // Combined blanking for the image about to be displayed.
  always_comb begin
    eff_blank = disp_next.blank | sup;
  end

  // Registered digit drive, refreshed once per tick from the new index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an     <= AN_OFF;
      nibble <= '0;
      dp_n   <= 1'b1;
    end else if (tick) begin
      if (eff_blank[idx_next]) begin
        an     <= AN_OFF;
        nibble <= '0;
        dp_n   <= 1'b1;
      end else begin
        an     <= ~(4'b0001 << idx_next);
        nibble <= digit_nibble(disp_next.data, idx_next);
        dp_n   <= ~disp_next.dp[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_x7seg_scan.sv
// Directed self-checking bench for x7seg_scan with REFRESH_DIV = 4.
// Time reference: N_k is the k-th falling edge after reset release;
// ticks are sampled on rising edges 4,8,12,...; frame boundaries on 16,32,...
module tb_x7seg_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [3:0]  nibble;
  logic        dp_n;
  logic        busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int now    = 0;

  logic [3:0] an_tab [4];

  x7seg_scan #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .data   (data),
    .blank  (blank),
    .dp     (dp),
    .an     (an),
    .nibble (nibble),
    .dp_n   (dp_n),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (now < n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic chk_slot(input string tag, input int at, input logic [3:0] an_e,
                          input logic [3:0] nib_e, input logic dpn_e);
    wait_until(at);
    chk({tag, "_an"},  {28'd0, an},     {28'd0, an_e});
    chk({tag, "_nib"}, {28'd0, nibble}, {28'd0, nib_e});
    chk({tag, "_dpn"}, {31'd0, dp_n},   {31'd0, dpn_e});
  endtask

  task automatic do_load(input int at, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    wait_until(at);
    load  = 1'b1;
    data  = d;
    blank = b;
    dp    = p;
    wait_until(at + 1);
    load  = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_nib [4];
    an_tab[0] = 4'b1110;
    an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011;
    an_tab[3] = 4'b0111;

    rst_n = 1'b0;
    load  = 1'b0;
    data  = '0;
    blank = '0;
    dp    = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_an",   {28'd0, an},     32'hF);
    chk("rst_nib",  {28'd0, nibble}, 32'h0);
    chk("rst_dpn",  {31'd0, dp_n},   32'h1);
    chk("rst_busy", {31'd0, busy},   32'h0);

    rst_n = 1'b1;
    now   = 0;

    // Basic load, busy until boundary, first tick timing
    do_load(1, 16'h1234, 4'b0000, 4'b0000);
    chk("busy_set", {31'd0, busy}, 32'h1);
    wait_until(3);
    chk("pre_tick_an", {28'd0, an}, 32'hF);
    chk_slot("old_d1", 4, 4'b1101, 4'h0, 1'b1);
    wait_until(15);
    chk("busy_hold", {31'd0, busy}, 32'h1);
    exp_nib[0] = 4'h4; exp_nib[1] = 4'h3; exp_nib[2] = 4'h2; exp_nib[3] = 4'h1;
    for (int k = 0; k < 4; k++) begin
      chk_slot($sformatf("f1234_s%0d", k), 16 + 4*k, an_tab[k], exp_nib[k], 1'b1);
      if (k == 0) chk("busy_clr", {31'd0, busy}, 32'h0);
      chk_slot($sformatf("f1234_e%0d", k), 19 + 4*k, an_tab[k], exp_nib[k], 1'b1);
    end

    // Last load wins
    do_load(33, 16'h1234, 4'b0000, 4'b0000);
    do_load(35, 16'hABCD, 4'b0000, 4'b0000);
    chk_slot("old_hold_d2", 40, 4'b1011, 4'h2, 1'b1);
    wait_until(47);
    chk("busy_lw", {31'd0, busy}, 32'h1);
    exp_nib[0] = 4'hD; exp_nib[1] = 4'hC; exp_nib[2] = 4'hB; exp_nib[3] = 4'hA;
    for (int k = 0; k < 4; k++)
      chk_slot($sformatf("fabcd_s%0d", k), 48 + 4*k, an_tab[k], exp_nib[k], 1'b1);

    // Load coincident with boundary tick
    wait_until(63);
    chk("busy_pre_co", {31'd0, busy}, 32'h0);
    do_load(63, 16'h5678, 4'b0000, 4'b0000);
    chk("busy_co", {31'd0, busy}, 32'h0);
    exp_nib[0] = 4'h8; exp_nib[1] = 4'h7; exp_nib[2] = 4'h6; exp_nib[3] = 4'h5;
    for (int k = 0; k < 4; k++) begin
      chk_slot($sformatf("f5678_s%0d", k), 64 + 4*k, an_tab[k], exp_nib[k], 1'b1);
      chk($sformatf("busy_co_%0d", k), {31'd0, busy}, 32'h0);
    end

    // Blank digit 2, decimal point on digit 0
    do_load(81, 16'h9876, 4'b0100, 4'b0001);
    chk_slot("bl_d0", 96,  4'b1110, 4'h6, 1'b0);
    chk_slot("bl_d1", 100, 4'b1101, 4'h7, 1'b1);
    chk_slot("bl_d2", 104, 4'b1111, 4'h0, 1'b1);
    chk_slot("bl_d3", 108, 4'b0111, 4'h9, 1'b1);

    // Leading zeros all light in the default build
    do_load(113, 16'h0070, 4'b0000, 4'b0000);
    exp_nib[0] = 4'h0; exp_nib[1] = 4'h7; exp_nib[2] = 4'h0; exp_nib[3] = 4'h0;
    for (int k = 0; k < 4; k++)
      chk_slot($sformatf("f0070_s%0d", k), 128 + 4*k, an_tab[k], exp_nib[k], 1'b1);

    // Asynchronous reset mid-frame with a pending value
    do_load(145, 16'hABCD, 4'b0000, 4'b0000);
    chk("busy_prerst", {31'd0, busy}, 32'h1);
    chk_slot("prerst", 150, 4'b1101, 4'h7, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an",   {28'd0, an},     32'hF);
    chk("arst_nib",  {28'd0, nibble}, 32'h0);
    chk("arst_dpn",  {31'd0, dp_n},   32'h1);
    chk("arst_busy", {31'd0, busy},   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    now   = 0;
    chk_slot("post_d1", 4, 4'b1101, 4'h0, 1'b1);
    wait_until(15);
    chk("post_busy", {31'd0, busy}, 32'h0);
    for (int k = 0; k < 4; k++)
      chk_slot($sformatf("post_s%0d", k), 16 + 4*k, an_tab[k], 4'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
